// File: rtl/repsub_divider.sv
// rtl/repsub_divider.sv - sequential unsigned divider using repeated subtraction
//
// Purpose:
//   Computes quotient and remainder of two WIDTH-bit unsigned operands.
//   Each subtraction of the divisor from the running remainder takes one clock.
//   Operands arrive serially on one shared bus: the dividend first, then the divisor.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, has priority over everything
//   start        request a division; only sampled in IDLE or DONE
//   data_in      operand bus: dividend in LOAD_A, divisor in LOAD_B
//   quotient     quotient counter Q (intermediate values visible while computing)
//   remainder    running remainder register A
//   busy         high while loading or computing
//   done         high in DONE; quotient/remainder are valid while it is high
//   div_by_zero  high in DONE when the loaded divisor was zero

module repsub_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] a;  // dividend, then running remainder
  logic [WIDTH-1:0] b;  // divisor
  logic [WIDTH-1:0] q;  // quotient counter

  // Results are read straight from the datapath registers.
  assign quotient  = q;
  assign remainder = a;

  // busy and done are registered alongside the state so that they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a           <= ZERO;
      b           <= ZERO;
      q           <= ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD_A;
            busy  <= 1'b1;
          end
        end

        S_LOAD_A: begin
          a     <= data_in;
          state <= S_LOAD_B;
        end

        S_LOAD_B: begin
          // The previous result's div_by_zero stays visible until this edge.
          b           <= data_in;
          q           <= ZERO;
          div_by_zero <= 1'b0;
          state       <= S_COMPUTE;
        end

        S_COMPUTE: begin
          if (b == ZERO) begin
            // Leave A holding the dividend so the caller can still see it.
            div_by_zero <= 1'b1;
            q           <= ZERO;
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (a >= b) begin
            // Guarded by a >= b, so this never wraps; q is bounded by the dividend.
            a <= a - b;
            q <= q + ONE;
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          // Back-to-back launch: done drops on the same edge that accepts start.
          if (start) begin
            state <= S_LOAD_A;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repsub_divider.sv
// tb/tb_repsub_divider.sv - self-checking bench for repsub_divider

module tb_repsub_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  bit          sel8 = 1'b0;

  logic [15:0] q16, r16;
  logic        busy16, done16, dbz16;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dbz8;
  logic        start16, start8;

  logic [15:0] q_m, r_m;
  logic        busy_m, done_m, dbz_m;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] trace[$];

  always #5 clk = ~clk;

  assign start16 = start & ~sel8;
  assign start8  = start & sel8;
  assign q_m     = sel8 ? {8'h00, q8} : q16;
  assign r_m     = sel8 ? {8'h00, r8} : r16;
  assign busy_m  = sel8 ? busy8 : busy16;
  assign done_m  = sel8 ? done8 : done16;
  assign dbz_m   = sel8 ? dbz8 : dbz16;

  repsub_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .data_in(data_in),
    .quotient(q16), .remainder(r16), .busy(busy16), .done(done16), .div_by_zero(dbz16)
  );

  repsub_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data_in[7:0]),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  typedef struct {
    bit          w8;
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Entered at a negedge with start low. Returns at the negedge where done is
  // first seen high; lat counts rising edges from the start-accepting edge.
  // poke pulses start during LOAD_B and COMPUTE, which must have no effect.
  task automatic do_op(input logic [15:0] dvd, input logic [15:0] dvs, input bit poke,
                       output int lat);
    trace.delete();
    start = 1'b1;
    data_in = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data_in = dvd;
    chk("busy_after_accept", busy_m, 1);
    chk("done_low_after_accept", done_m, 0);
    @(posedge clk);
    @(negedge clk);
    data_in = dvs;
    start = poke;
    @(posedge clk);
    @(negedge clk);
    start = poke;
    lat = 2;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      trace.push_back(r_m);
      if (done_m) break;
      if (lat > 400) begin
        lat = -1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [15:0] dvd, dvs;
    bit seen;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] dvd, dvs;
    bit seen;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", q16, 0);
    chk("rst_remainder", r16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_dbz", dbz16, 0);
    chk("rst_done8", done8, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy16, 0);

    // Basic 17/5 with the remainder walking 17 -> 12 -> 7 -> 2
    sel8 = 1'b0;
    do_op(16'd17, 16'd5, 1'b0, lat);
    chk("basic_step1", trace[0], 12);
    chk("basic_step2", trace[1], 7);
    chk("basic_step3", trace[2], 2);
    chk("basic_q", q_m, 3);
    chk("basic_r", r_m, 2);
    chk("basic_dbz", dbz_m, 0);
    chk("basic_lat", lat, 6);

    // Table of vectors: expectations worked out by hand
    vecs.push_back('{0, 16'd9,     16'd0,     16'd0,   16'd9,   1'b1, 3});
    vecs.push_back('{0, 16'd0,     16'd7,     16'd0,   16'd0,   1'b0, 3});
    vecs.push_back('{0, 16'd4,     16'd9,     16'd0,   16'd4,   1'b0, 3});
    vecs.push_back('{0, 16'd8,     16'd8,     16'd1,   16'd0,   1'b0, 4});
    vecs.push_back('{1, 16'd255,   16'd1,     16'd255, 16'd0,   1'b0, 258});
    vecs.push_back('{0, 16'd1000,  16'd3,     16'd333, 16'd1,   1'b0, 336});
    vecs.push_back('{0, 16'd65535, 16'd65535, 16'd1,   16'd0,   1'b0, 4});
    vecs.push_back('{0, 16'd65535, 16'd256,   16'd255, 16'd255, 1'b0, 258});
    vecs.push_back('{1, 16'd200,   16'd0,     16'd0,   16'd200, 1'b1, 3});
    foreach (vecs[i]) begin
      sel8 = vecs[i].w8;
      do_op(vecs[i].dvd, vecs[i].dvs, 1'b0, lat);
      chk($sformatf("vec%0d_q", i), q_m, vecs[i].exp_q);
      chk($sformatf("vec%0d_r", i), r_m, vecs[i].exp_r);
      chk($sformatf("vec%0d_dbz", i), dbz_m, vecs[i].exp_dbz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Divide by zero, then a new start clears div_by_zero only on the LOAD_B edge
    sel8 = 1'b0;
    do_op(16'd9, 16'd0, 1'b0, lat);
    chk("dbz_flag", dbz_m, 1);
    chk("dbz_r", r_m, 9);
    chk("dbz_lat", lat, 3);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd20;
    chk("dbz_hold_load_a", dbz_m, 1);
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd6;
    chk("dbz_hold_load_b", dbz_m, 1);
    @(posedge clk);
    @(negedge clk);
    chk("dbz_cleared", dbz_m, 0);
    chk("dbz_next_busy", busy_m, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = done_m;
    end
    chk("dbz_next_done", seen, 1);
    chk("dbz_next_q", q_m, 3);
    chk("dbz_next_r", r_m, 2);

    // start pulses while busy are ignored; then a back-to-back launch from DONE
    do_op(16'd100, 16'd7, 1'b1, lat);
    chk("poke_q", q_m, 14);
    chk("poke_r", r_m, 2);
    chk("poke_lat", lat, 17);
    do_op(16'd20, 16'd6, 1'b0, lat);
    chk("b2b_q", q_m, 3);
    chk("b2b_r", r_m, 2);
    chk("b2b_lat", lat, 6);

    // Reset mid-COMPUTE of 50/3 once A reaches 35
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd50;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd3;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = (r_m == 16'd35) && busy_m;
    end
    chk("midrst_reached_35", seen, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_q", q_m, 0);
    chk("midrst_r", r_m, 0);
    chk("midrst_busy", busy_m, 0);
    chk("midrst_done", done_m, 0);
    chk("midrst_dbz", dbz_m, 0);
    @(negedge clk);
    chk("midrst_stays_idle", {busy_m, done_m}, 0);
    do_op(16'd10, 16'd3, 1'b0, lat);
    chk("after_rst_q", q_m, 3);
    chk("after_rst_r", r_m, 1);
    chk("after_rst_lat", lat, 6);

    // Random 8-bit pairs against plain arithmetic
    sel8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      dvd = 16'($urandom_range(0, 255));
      dvs = 16'($urandom_range(1, 255));
      do_op(dvd, dvs, 1'b0, lat);
      chk($sformatf("rnd%0d_q(%0d/%0d)", i, dvd, dvs), q_m, dvd / dvs);
      chk($sformatf("rnd%0d_r(%0d/%0d)", i, dvd, dvs), r_m, dvd % dvs);
      chk($sformatf("rnd%0d_dbz", i), dbz_m, 0);
      chk($sformatf("rnd%0d_lat", i), lat, (dvd / dvs) + 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
